// File: rtl/qk_mac_pkg.sv
// Shared types, default sizes and the lane dot-product helper for the Q·K engine.
package qk_mac_pkg;

  localparam int BW_DEF         = 8;
  localparam int PR_DEF         = 8;
  localparam int BW_PSUM_DEF    = 2 * BW_DEF + 4;
  localparam int COL_DEF        = 8;
  localparam int Q_DEPTH_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int VEC_MAX        = 512;

  typedef enum logic [1:0] {IDLE, RUN, PUSH, DONE} state_t;

  // Vectors arrive zero-extended to VEC_MAX bits. Each lane is sign-extended from bw bits.
  // Callers truncate the 64-bit sum to their psum width, which gives modulo-2^width wrap.
  // Supports element widths up to 16 bits.
  function automatic logic signed [63:0] dot_pr(input logic [VEC_MAX-1:0] q,
                                                input logic [VEC_MAX-1:0] k,
                                                input int unsigned bw,
                                                input int unsigned pr);
    logic signed [63:0] acc;
    logic signed [31:0] qe;
    logic signed [31:0] ke;
    int unsigned idx;
    acc = '0;
    for (int unsigned p = 0; p < pr; p++) begin
      for (int unsigned b = 0; b < 32; b++) begin
        if (b < bw) idx = p * bw + b;
        else        idx = p * bw + bw - 1;
        qe[b] = q[idx];
        ke[b] = k[idx];
      end
      acc = acc + 64'(qe * ke);
    end
    return acc;
  endfunction

endpackage

// File: rtl/qk_out_fifo.sv
// Synchronous valid/ready FIFO for finished result rows; active-low synchronous reset.
module qk_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full      = (cnt == (PW+1)'(DEPTH));
  assign out_valid = (cnt != '0);
  assign do_push   = push && !full;
  assign do_pop    = out_valid && out_ready;
  assign out_data  = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (do_pop)  rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/qk_mac_engine.sv
// Self-sequenced Q·K dot-product engine with Q/K register stores and an output row FIFO.
// Build option: define MAC_RELU_EN to clamp negative column sums to 0 at push time.
module qk_mac_engine
  import qk_mac_pkg::*;
#(
  parameter int BW         = BW_DEF,
  parameter int BW_PSUM    = BW_PSUM_DEF,
  parameter int PR         = PR_DEF,
  parameter int COL        = COL_DEF,
  parameter int Q_DEPTH    = Q_DEPTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int AW        = $clog2(Q_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [AW-1:0]          wr_addr,
  input  logic [PR*BW-1:0]       wr_data,
  input  logic                   start,
  input  logic [AW:0]            num_q,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*BW_PSUM-1:0] out_data,
  output logic [AW-1:0]          out_row
);

  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int FW = COL * BW_PSUM + AW;

  logic [PR*BW-1:0]       q_mem [Q_DEPTH];
  logic [PR*BW-1:0]       k_mem [COL];
  logic [BW_PSUM-1:0]     psum  [COL];
  logic [COL*BW_PSUM-1:0] psum_vec;

  state_t        state;
  logic [AW-1:0] r;
  logic [CW-1:0] c;
  logic [AW:0]   nq;
  logic          push;
  logic          fifo_full;
  logic          fifo_valid;
  logic [FW-1:0] fifo_data;

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      if (!wr_sel) begin
        if (32'(wr_addr) < Q_DEPTH) q_mem[wr_addr] <= wr_data;
      end else begin
        if (32'(wr_addr[CW-1:0]) < COL) k_mem[wr_addr[CW-1:0]] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == RUN)
      psum[c] <= BW_PSUM'(dot_pr(VEC_MAX'(q_mem[r]), VEC_MAX'(k_mem[c]), BW, PR));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
      nq    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      err  <= wr_en && busy;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r    <= '0;
            c    <= '0;
            nq   <= (num_q > (AW+1)'(Q_DEPTH)) ? (AW+1)'(Q_DEPTH) : num_q;
            busy <= 1'b1;
            if (num_q == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (c == CW'(COL - 1)) state <= PUSH;
          else                   c     <= c + 1'b1;
        end
        PUSH: begin
          // A full FIFO stalls here with psums held; the push itself is gated inside the FIFO.
          if (!fifo_full) begin
            if ({1'b0, r} == nq - 1'b1) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              r     <= r + 1'b1;
              c     <= '0;
              state <= RUN;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    psum_vec = '0;
    for (int unsigned i = 0; i < COL; i++) begin
`ifdef MAC_RELU_EN
      psum_vec[i*BW_PSUM +: BW_PSUM] = psum[i][BW_PSUM-1] ? '0 : psum[i];
`else
      psum_vec[i*BW_PSUM +: BW_PSUM] = psum[i];
`endif
    end
  end

  assign push = (state == PUSH);

  qk_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({psum_vec, r}),
    .full      (fifo_full),
    .out_valid (fifo_valid),
    .out_ready (out_ready),
    .out_data  (fifo_data)
  );

  assign out_valid = fifo_valid;
  assign out_data  = fifo_valid ? fifo_data[FW-1:AW] : '0;
  assign out_row   = fifo_valid ? fifo_data[AW-1:0]  : '0;

endmodule

// File: tb/tb_qk_mac_engine.sv
// Directed bench for qk_mac_engine: scoreboard of expected rows built from a lane-level model.
module tb_qk_mac_engine;

  localparam int BW = 8, PR = 8, COL = 8, QD = 16, AW = 4, PS = 20;
  localparam int W  = COL * PS + AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [63:0]   wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   num_q = '0;
  logic          busy, done, err, out_valid;
  logic          out_ready = 1'b1;
  logic [COL*PS-1:0] out_data;
  logic [AW-1:0] out_row;

  qk_mac_engine #(
    .BW (BW), .BW_PSUM (PS), .PR (PR), .COL (COL), .Q_DEPTH (QD), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .reset (reset), .wr_en (wr_en), .wr_sel (wr_sel), .wr_addr (wr_addr),
    .wr_data (wr_data), .start (start), .num_q (num_q), .busy (busy), .done (done),
    .err (err), .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_row (out_row)
  );

  always #5 clk = ~clk;

  int qm [QD][PR];
  int km [COL][PR];
  logic [W-1:0] sb [$];
  logic [W-1:0] last_data = '0;
  int checks = 0, failures = 0;
  int n_done = 0, n_rows = 0, n_valid = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_row(input int r);
    logic [COL*PS-1:0] d;
    longint s;
    d = '0;
    for (int c = 0; c < COL; c++) begin
      s = 0;
      for (int p = 0; p < PR; p++) s += longint'(qm[r][p] * km[c][p]);
`ifdef MAC_RELU_EN
      if (s < 0) s = 0;
`endif
      d[c*PS +: PS] = s[PS-1:0];
    end
    return {d, AW'(r)};
  endfunction

  function automatic logic [63:0] rep(input int x);
    logic [7:0] b;
    b = x[7:0];
    return {8{b}};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int addr, input logic [63:0] v);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = v;
    for (int p = 0; p < PR; p++) begin
      if (sel) km[addr][p] = int'($signed(v[p*8 +: 8]));
      else     qm[addr][p] = int'($signed(v[p*8 +: 8]));
    end
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int n);
    int rows;
    rows = (n > QD) ? QD : n;
    num_q = (AW+1)'(n);
    for (int r = 0; r < rows; r++) sb.push_back(exp_row(r));
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit rnd);
    int t;
    t = 0;
    while ((busy || sb.size() != 0) && t < 500) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else     out_ready = 1'b1;
      t++;
    end
    out_ready = 1'b1;
    chk(tag, 256'(t < 500), 256'(1));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        n_valid++;
        if (out_ready) begin
          if (sb.size() == 0) chk("unexpected_row", 256'({out_data, out_row}), 256'(0));
          else chk("row", 256'({out_data, out_row}), 256'(sb.pop_front()));
          last_data = {out_data, out_row};
          n_rows++;
        end
      end else begin
        chk("idle_data_zero", 256'({out_data, out_row}), 256'(0));
      end
      if (done) n_done++;
    end
  end

  initial begin
    int k, d0, r0, v0;

    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_data", 256'(out_data), 256'(0));
    chk("rst_row", 256'(out_row), 256'(0));
    reset = 1'b1;
    tick(1);

    // 1: basic run and first-output latency
    for (int c = 0; c < COL; c++) wr(1'b1, c, rep(c + 1));
    wr(1'b0, 0, rep(1));
    d0 = n_done; r0 = n_rows;
    start_run(1);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 50);
    chk("first_valid_lat", 256'(k), 256'(COL + 2));
    wait_idle("basic_timeout", 1'b0);
    chk("basic_done_cnt", 256'(n_done - d0), 256'(1));
    chk("basic_rows", 256'(n_rows - r0), 256'(1));
    chk("basic_col0", 256'(last_data[AW +: PS]), 256'(8));
    chk("basic_col7", 256'(last_data[AW + 7*PS +: PS]), 256'(64));

    // 2: signed corner products
    wr(1'b0, 0, rep(-128));
    wr(1'b1, 0, rep(-128));
    wr(1'b1, 1, rep(127));
    start_run(1);
    wait_idle("corner_timeout", 1'b0);
    chk("corner_col0", 256'(last_data[AW +: PS]), 256'(20'd131072));
`ifdef MAC_RELU_EN
    chk("corner_col1", 256'(last_data[AW + PS +: PS]), 256'(0));
`else
    chk("corner_col1", 256'(last_data[AW + PS +: PS]), 256'(20'hE0400));
`endif
    wr(1'b0, 0, rep(1));
    wr(1'b1, 0, rep(1));
    wr(1'b1, 1, rep(2));

    // 3: backpressure with a full FIFO
    for (int r = 1; r < 8; r++) wr(1'b0, r, {$urandom, $urandom});
    out_ready = 1'b0;
    d0 = n_done; r0 = n_rows;
    start_run(8);
    tick(60);
    @(negedge clk);
    chk("bp_busy", 256'(busy), 256'(1));
    chk("bp_valid", 256'(out_valid), 256'(1));
    chk("bp_no_done", 256'(n_done - d0), 256'(0));
    chk("bp_sb_pending", 256'(sb.size()), 256'(8));
    wait_idle("bp_timeout", 1'b1);
    chk("bp_rows", 256'(n_rows - r0), 256'(8));
    chk("bp_done_cnt", 256'(n_done - d0), 256'(1));

    // 4: empty run, then clamped oversize run
    d0 = n_done; v0 = n_valid;
    start_run(0);
    @(negedge clk);
    chk("empty_done", 256'(done), 256'(1));
    tick(6);
    chk("empty_no_valid", 256'(n_valid - v0), 256'(0));
    chk("empty_done_cnt", 256'(n_done - d0), 256'(1));
    for (int r = 8; r < QD; r++) wr(1'b0, r, {$urandom, $urandom});
    r0 = n_rows;
    start_run(20);
    wait_idle("clamp_timeout", 1'b1);
    chk("clamp_rows", 256'(n_rows - r0), 256'(16));

    // 5: write and second start while busy are rejected
    d0 = n_done; r0 = n_rows;
    start_run(1);
    tick(2);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = rep(99);
    tick(1);
    wr_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("err_pulse", 256'(err), 256'(1));
    tick(1);
    start = 1'b0;
    @(negedge clk);
    chk("err_cleared", 256'(err), 256'(0));
    wait_idle("busy_wr_timeout", 1'b0);
    tick(20);
    chk("restart_ignored_done", 256'(n_done - d0), 256'(1));
    chk("restart_ignored_rows", 256'(n_rows - r0), 256'(1));
    chk("restart_ignored_busy", 256'(busy), 256'(0));
    start_run(1);
    wait_idle("rerun_timeout", 1'b0);
    chk("q0_retained", 256'(last_data[AW + 2*PS +: PS]), 256'(24));

    // 6: reset mid-run aborts silently, stores retained
    d0 = n_done;
    start_run(1);
    tick(5);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_valid", 256'(out_valid), 256'(0));
    chk("abort_done", 256'(done), 256'(0));
    tick(20);
    chk("abort_no_done", 256'(n_done - d0), 256'(0));
    r0 = n_rows;
    start_run(1);
    wait_idle("post_reset_timeout", 1'b0);
    chk("post_reset_rows", 256'(n_rows - r0), 256'(1));
    chk("post_reset_col0", 256'(last_data[AW +: PS]), 256'(8));
    chk("post_reset_col7", 256'(last_data[AW + 7*PS +: PS]), 256'(64));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
